// File: rtl/channel_sched.sv
// Round-robin arbiter and burst sequencer for the shared 10-bit transmit/receive channel.
// Drives the transmitter's enable/clr, counts receiver words and aborts stalled bursts.
module channel_sched #(
  parameter int BURST_LEN  = 8,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [1:0]       req,
  input  logic             data_valid,
  output logic             tran_enable,
  output logic             tran_clr,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DONE, ABORT} state_t;

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_t           state;
  logic             rr_ptr;
  logic             pick;
  logic [CLR_W-1:0] clr_cnt;
  logic [TMR_W-1:0] timer;

  // Favoured requester wins if asking, otherwise the other one.
  always_comb begin
    pick = req[rr_ptr] ? rr_ptr : ~rr_ptr;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      clr_cnt     <= '0;
      timer       <= '0;
      tran_enable <= 1'b0;
      tran_clr    <= 1'b0;
      grant       <= '0;
      done        <= '0;
      err         <= '0;
      word_cnt    <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            grant    <= pick ? 2'b10 : 2'b01;
            rr_ptr   <= ~pick;
            word_cnt <= '0;
            clr_cnt  <= '0;
            tran_clr <= 1'b1;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            tran_clr    <= 1'b0;
            tran_enable <= 1'b1;
            timer       <= '0;
            state       <= RUN;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN: begin
          // A word arriving on the expiry cycle takes priority over the abort.
          if (data_valid) begin
            word_cnt <= word_cnt + 1'b1;
            timer    <= '0;
            if (word_cnt == CNT_LAST) begin
              tran_enable <= 1'b0;
              done        <= grant;
              state       <= DONE;
            end
          end else if (timer == TMR_LAST) begin
            tran_enable <= 1'b0;
            tran_clr    <= 1'b1;
            err         <= grant;
            state       <= ABORT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          grant <= '0;
          state <= IDLE;
        end
        ABORT: begin
          tran_clr <= 1'b0;
          grant    <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_sched.sv
// Directed bench for channel_sched: inline checks plus a scoreboard of expected
// done/err completions popped whenever the DUT pulses one.
module tb_channel_sched;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [1:0] req;
  logic       data_valid;
  logic       tran_enable;
  logic       tran_clr;
  logic [1:0] grant;
  logic [1:0] done;
  logic [1:0] err;
  logic [3:0] word_cnt;

  typedef struct packed {
    logic [1:0] d;
    logic [1:0] e;
    logic [3:0] c;
  } ev_t;

  ev_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  channel_sched #(.BURST_LEN(8), .CLR_CYCLES(2), .TIMEOUT(16), .CNT_W(4)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .req        (req),
    .data_valid (data_valid),
    .tran_enable(tran_enable),
    .tran_clr   (tran_clr),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] d, input logic [1:0] e, input logic [3:0] c);
    ev_t ev;
    ev.d = d;
    ev.e = e;
    ev.c = c;
    sb.push_back(ev);
  endtask

  // Wait (bounded) for a grant, then walk the two CLEAR cycles into RUN.
  task automatic start(input logic [1:0] eg, input logic dv_clear);
    int n = 0;
    while (grant == 2'b00 && n < 4) begin
      cyc(1);
      n++;
    end
    chk("grant", {6'd0, grant}, {6'd0, eg});
    chk("clr_on", {7'd0, tran_clr}, 8'd1);
    chk("en_off", {7'd0, tran_enable}, 8'd0);
    chk("wc_clear", {4'd0, word_cnt}, 8'd0);
    data_valid = dv_clear;
    cyc(1);
    chk("clr_hold", {7'd0, tran_clr}, 8'd1);
    cyc(1);
    data_valid = 1'b0;
    chk("en_on", {7'd0, tran_enable}, 8'd1);
    chk("clr_off", {7'd0, tran_clr}, 8'd0);
    chk("wc_run0", {4'd0, word_cnt}, 8'd0);
  endtask

  task automatic pulses(input int n, input int gap, input int base);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      cyc(1);
      data_valid = 1'b0;
      chk("wc_step", {4'd0, word_cnt}, 8'(base + i + 1));
      if (i != n - 1) cyc(gap);
    end
  endtask

  task automatic full_burst(input logic [1:0] eg, input int gap);
    start(eg, 1'b0);
    push(eg, 2'b00, 4'd8);
    pulses(8, gap, 0);
    chk("done_pulse", {6'd0, done}, {6'd0, eg});
    chk("done_en", {7'd0, tran_enable}, 8'd0);
    cyc(1);
    chk("done_clear", {6'd0, done}, 8'd0);
    chk("grant_idle", {6'd0, grant}, 8'd0);
    chk("wc_hold", {4'd0, word_cnt}, 8'd8);
  endtask

  // Completion scoreboard and structural invariants.
  always @(negedge clk) begin
    if (clr_n === 1'b1) begin
      chk("inv_grant", {7'd0, ((grant & (grant - 2'b01)) == 2'b00)}, 8'd1);
      chk("inv_en_clr", {7'd0, (tran_enable & tran_clr)}, 8'd0);
      chk("inv_done_err", {7'd0, ((done != 2'b00) && (err != 2'b00))}, 8'd0);
      if (done != 2'b00 || err != 2'b00) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", {done, err, word_cnt}, 8'd0);
        end else begin
          ev_t ev;
          ev = sb.pop_front();
          chk("sb_event", {done, err, word_cnt}, ev);
        end
      end
    end
  end

  initial begin
    // 1: reset holds everything low regardless of inputs
    clr_n = 1'b0;
    req = 2'b00;
    data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req = 2'(i);
      data_valid = i[0];
      cyc(1);
      chk("rst_outs", {tran_enable, tran_clr, grant, done, err}, 8'd0);
      chk("rst_wc", {4'd0, word_cnt}, 8'd0);
    end
    req = 2'b00;
    data_valid = 1'b0;
    clr_n = 1'b1;
    cyc(3);
    chk("idle_stay", {tran_enable, tran_clr, grant, done, err}, 8'd0);

    // 2: single burst, words every other cycle, req dropped after grant
    req = 2'b01;
    start(2'b01, 1'b0);
    req = 2'b00;
    push(2'b01, 2'b00, 4'd8);
    pulses(8, 1, 0);
    chk("done_pulse", {6'd0, done}, 8'd1);
    cyc(1);
    chk("grant_idle", {6'd0, grant}, 8'd0);
    chk("done_clear", {6'd0, done}, 8'd0);
    cyc(2);
    chk("no_regrant", {6'd0, grant}, 8'd0);

    // 3: reset brings rr_ptr back to req[0], then alternation under req=11
    #2 clr_n = 1'b0;
    #2 clr_n = 1'b1;
    cyc(1);
    req = 2'b11;
    full_burst(2'b01, 0);
    full_burst(2'b10, 0);
    full_burst(2'b01, 0);
    req = 2'b00;
    cyc(2);

    // 4: timeout after three words; data_valid during CLEAR is not counted
    req = 2'b10;
    start(2'b10, 1'b1);
    req = 2'b00;
    push(2'b00, 2'b10, 4'd3);
    pulses(3, 1, 0);
    cyc(15);
    chk("to_not_yet", {6'd0, err}, 8'd0);
    chk("to_still_run", {7'd0, tran_enable}, 8'd1);
    cyc(1);
    chk("to_err", {6'd0, err}, 8'h2);
    chk("to_clr", {7'd0, tran_clr}, 8'd1);
    chk("to_en", {7'd0, tran_enable}, 8'd0);
    chk("to_wc", {4'd0, word_cnt}, 8'd3);
    cyc(1);
    chk("to_err_off", {6'd0, err}, 8'd0);
    chk("to_clr_off", {7'd0, tran_clr}, 8'd0);
    chk("to_grant_off", {6'd0, grant}, 8'd0);
    chk("to_wc_hold", {4'd0, word_cnt}, 8'd3);

    // 5: word on the expiry cycle wins and restarts the timer
    req = 2'b01;
    start(2'b01, 1'b0);
    req = 2'b00;
    pulses(1, 0, 0);
    cyc(15);
    data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    chk("bd_no_err", {6'd0, err}, 8'd0);
    chk("bd_wc", {4'd0, word_cnt}, 8'd2);
    chk("bd_run", {7'd0, tran_enable}, 8'd1);
    push(2'b00, 2'b01, 4'd2);
    cyc(15);
    chk("bd_restart", {6'd0, err}, 8'd0);
    cyc(1);
    chk("bd_err", {6'd0, err}, 8'd1);
    cyc(2);

    // 6: reset mid-burst, then a fresh burst counts from zero
    req = 2'b01;
    start(2'b01, 1'b0);
    pulses(5, 0, 0);
    chk("mr_wc5", {4'd0, word_cnt}, 8'd5);
    #2 clr_n = 1'b0;
    #1;
    chk("mr_outs", {tran_enable, tran_clr, grant, done, err}, 8'd0);
    chk("mr_wc", {4'd0, word_cnt}, 8'd0);
    req = 2'b00;
    cyc(1);
    #2 clr_n = 1'b1;
    cyc(1);
    chk("mr_idle", {6'd0, grant}, 8'd0);
    req = 2'b01;
    full_burst(2'b01, 0);
    req = 2'b00;
    cyc(3);

    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
